// File: rtl/ibus_req_arbiter.sv
// Instruction-bus request arbiter with an in-order response ID FIFO.
// Define IBUS_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.

package ibus_arb_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        hit;
      logic        excp;
      logic [19:0] ppn;
   } tu_op_resp_t;
endpackage

module ibus_req_arbiter
   import ibus_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  ibus_req_t               req_i     [NREQ],
   output ibus_resp_t              resp_o    [NREQ],
   output tu_op_resp_t             tu_resp_o [NREQ],
   output ibus_req_t               imem_req,
   input  ibus_resp_t              imem_resp,
   input  tu_op_resp_t             tu_resp,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy
);
   localparam int IW = $clog2(NREQ);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IW-1:0] grant_r;
   logic          lock_r;
   logic [IW-1:0] lock_id_r;
   logic [PW-1:0] wptr_r;
   logic [PW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic [IW-1:0] fifo_id_r   [DEPTH];
   logic          fifo_disc_r [DEPTH];

   logic [IW-1:0] arb_id_s;
   logic          any_valid_s;
   logic          locked_s;
   logic          full_s;
   logic          req_valid_s;
   logic          accept_s;
   logic          pop_s;
   logic          fwd_s;
   logic [IW-1:0] head_id_s;

`ifdef IBUS_ARB_RR_EN
   logic [IW-1:0] rr_ptr_r;

   // Rotating search starting at the requester after the last accepted one
   always_comb begin
      int idx;
      idx         = 0;
      arb_id_s    = grant_r;
      any_valid_s = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx         = (int'(rr_ptr_r) + k) % NREQ;
         arb_id_s    = req_i[idx].valid ? idx[IW-1:0] : arb_id_s;
         any_valid_s = any_valid_s | req_i[idx].valid;
      end
   end

   // Round-robin start pointer advances only when a request is accepted
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_r <= {IW{1'b0}};
      end else if (accept_s) begin
         rr_ptr_r <= (grant_id == IW'(NREQ - 1)) ? {IW{1'b0}} : grant_id + IW'(1'b1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`else
   // Fixed priority: lowest valid index wins
   always_comb begin
      arb_id_s    = grant_r;
      any_valid_s = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         arb_id_s    = req_i[k].valid ? IW'(k) : arb_id_s;
         any_valid_s = any_valid_s | req_i[k].valid;
      end
   end
`endif

   // Grant selection: a stalled request keeps the bus, otherwise hold when idle
   always_comb begin
      locked_s = lock_r & req_i[lock_id_r].valid;
      if (locked_s) begin
         grant_id = lock_id_r;
      end else if (any_valid_s) begin
         grant_id = arb_id_s;
      end else begin
         grant_id = grant_r;
      end
   end

   // Memory-side request, handshake routing and response forwarding
   always_comb begin
      full_s      = (count_r == CW'(DEPTH));
      req_valid_s = reset & ~flush & ~full_s & req_i[grant_id].valid;
      imem_req    = '{valid: req_valid_s, addr: req_i[grant_id].addr};
      accept_s    = req_valid_s & imem_resp.addr_ok;
      pop_s       = reset & imem_resp.data_ok & (count_r != {CW{1'b0}});
      head_id_s   = fifo_id_r[rptr_r];
      // Discarded heads and pops during flush are consumed without forwarding
      fwd_s       = pop_s & ~flush & ~fifo_disc_r[rptr_r];
      busy        = reset & (count_r != {CW{1'b0}});
      for (int i = 0; i < NREQ; i++) begin
         resp_o[i].addr_ok = req_valid_s & (grant_id == IW'(i)) & imem_resp.addr_ok;
         resp_o[i].data_ok = fwd_s & (head_id_s == IW'(i));
         resp_o[i].data    = (fwd_s && (head_id_s == IW'(i))) ? imem_resp.data : 32'h0000_0000;
         tu_resp_o[i]      = (req_valid_s && (grant_id == IW'(i))) ? tu_resp : '0;
      end
   end

   // Grant, lock and ID FIFO state
   always_ff @(posedge clk) begin
      if (!reset) begin
         grant_r   <= {IW{1'b0}};
         lock_r    <= 1'b0;
         lock_id_r <= {IW{1'b0}};
         wptr_r    <= {PW{1'b0}};
         rptr_r    <= {PW{1'b0}};
         count_r   <= {CW{1'b0}};
         for (int d = 0; d < DEPTH; d++) begin
            fifo_id_r[d]   <= {IW{1'b0}};
            fifo_disc_r[d] <= 1'b0;
         end
      end else begin
         grant_r   <= grant_id;
         lock_r    <= ~flush & ~accept_s & req_i[grant_id].valid & (req_valid_s | locked_s);
         lock_id_r <= grant_id;
         wptr_r    <= accept_s ? wptr_r + PW'(1'b1) : wptr_r;
         rptr_r    <= pop_s ? rptr_r + PW'(1'b1) : rptr_r;
         case ({accept_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
         for (int d = 0; d < DEPTH; d++) begin
            if (flush) begin
               fifo_disc_r[d] <= 1'b1;
            end else if (accept_s && (wptr_r == PW'(d))) begin
               fifo_disc_r[d] <= 1'b0;
               fifo_id_r[d]   <= grant_id;
            end else begin
               fifo_disc_r[d] <= fifo_disc_r[d];
            end
         end
      end
   end
endmodule

// File: tb/tb_ibus_req_arbiter.sv
// Directed table-driven bench for ibus_req_arbiter (NREQ=2, DEPTH=4).
module tb_ibus_req_arbiter;
   import ibus_arb_pkg::*;

   localparam int NREQ  = 2;
   localparam int DEPTH = 4;
`ifdef IBUS_ARB_RR_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        flush;
   ibus_req_t   req_i     [NREQ];
   ibus_resp_t  resp_o    [NREQ];
   tu_op_resp_t tu_resp_o [NREQ];
   ibus_req_t   imem_req;
   ibus_resp_t  imem_resp;
   tu_op_resp_t tu_resp;
   logic [0:0]  grant_id;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int step   = 0;

   // rst v0 v1 aok dok fl | expected: grant valid aok0 aok1 dok0 dok1 busy
   typedef struct packed {
      logic rst, v0, v1, aok, dok, fl;
      logic g, val, a0, a1, d0, d1, bsy;
   } vec_t;

   ibus_req_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .req_i     (req_i),
      .resp_o    (resp_o),
      .tu_resp_o (tu_resp_o),
      .imem_req  (imem_req),
      .imem_resp (imem_resp),
      .tu_resp   (tu_resp),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then check outputs
   task automatic run_row(input string nm, input vec_t v);
      logic [31:0] data;
      logic [31:0] exp_addr;
      step++;
      data = 32'hDA7A_0000 | step;
      @(negedge clk);
      reset             = v.rst;
      flush             = v.fl;
      req_i[0].valid    = v.v0;
      req_i[1].valid    = v.v1;
      imem_resp.addr_ok = v.aok;
      imem_resp.data_ok = v.dok;
      imem_resp.data    = data;
      #1;
      exp_addr = v.g ? 32'h0000_2000 : 32'h0000_1000;
      chk({nm, ".grant"},  {31'd0, grant_id},          {31'd0, v.g});
      chk({nm, ".valid"},  {31'd0, imem_req.valid},    {31'd0, v.val});
      chk({nm, ".aok0"},   {31'd0, resp_o[0].addr_ok}, {31'd0, v.a0});
      chk({nm, ".aok1"},   {31'd0, resp_o[1].addr_ok}, {31'd0, v.a1});
      chk({nm, ".dok0"},   {31'd0, resp_o[0].data_ok}, {31'd0, v.d0});
      chk({nm, ".dok1"},   {31'd0, resp_o[1].data_ok}, {31'd0, v.d1});
      chk({nm, ".data0"},  resp_o[0].data, v.d0 ? data : 32'h0);
      chk({nm, ".data1"},  resp_o[1].data, v.d1 ? data : 32'h0);
      chk({nm, ".busy"},   {31'd0, busy},              {31'd0, v.bsy});
      chk({nm, ".tu0"},    {8'd0, tu_resp_o[0]}, (v.val && !v.g) ? {8'd0, tu_resp} : 32'h0);
      chk({nm, ".tu1"},    {8'd0, tu_resp_o[1]}, (v.val &&  v.g) ? {8'd0, tu_resp} : 32'h0);
      if (v.val) begin
         chk({nm, ".addr"}, imem_req.addr, exp_addr);
      end
   endtask

   vec_t tbl [15];

   initial begin
      tbl[0]  = 13'b111100_0110000;
      tbl[1]  = {6'b111100, RR, 1'b1, ~RR, RR, 2'b00, 1'b1};
      tbl[2]  = 13'b111100_0110001;
      tbl[3]  = 13'b100010_0000101;
      tbl[4]  = {6'b100010, 4'b0000, ~RR, RR, 1'b1};
      tbl[5]  = 13'b100010_0000101;
      tbl[6]  = 13'b100010_0000000;
      tbl[7]  = 13'b100000_0000000;
      tbl[8]  = 13'b101100_1101000;
      tbl[9]  = 13'b110100_0110001;
      tbl[10] = 13'b101100_1101001;
      tbl[11] = 13'b100010_1000011;
      tbl[12] = 13'b100010_1000101;
      tbl[13] = 13'b100010_1000011;
      tbl[14] = 13'b100000_1000000;

      reset          = 1'b0;
      flush          = 1'b0;
      req_i[0]       = '{valid: 1'b1, addr: 32'h0000_1000};
      req_i[1]       = '{valid: 1'b1, addr: 32'h0000_2000};
      imem_resp      = '0;
      tu_resp        = '{hit: 1'b1, excp: 1'b0, ppn: 20'h12345};
      repeat (2) @(posedge clk);

      // Reset state with both requesters asserting
      run_row("rst0", 13'b011000_0000000);
      run_row("rst1", 13'b011000_0000000);

      for (int i = 0; i < 15; i++) begin
         run_row($sformatf("tbl%0d", i), tbl[i]);
      end

      // Lock while addr_ok is held low, then flush clears lock and discards
      run_row("lock1", 13'b101000_1100000);
      run_row("lock2", 13'b111000_1100000);
      run_row("lock3", 13'b111000_1100000);
      run_row("lock4", 13'b111100_1101000);
      run_row("lock5", 13'b111100_0110001);
      run_row("lock6", 13'b101000_1100001);
      run_row("flush", 13'b111101_1000001);
      run_row("unlck", {6'b111000, RR, 1'b1, 4'b0000, 1'b1});
      run_row("disc1", {6'b100010, RR, 5'b00000, 1'b1});
      run_row("disc2", {6'b100010, RR, 5'b00000, 1'b1});
      run_row("idle1", {6'b100000, RR, 6'b000000});

      // Pop in the flush cycle is consumed silently
      run_row("fpush", 13'b110100_0110000);
      run_row("fpop",  13'b100011_0000001);
      run_row("idle2", 13'b100000_0000000);

      // Full FIFO blocks accepts, even with a same-cycle pop
      run_row("full1", 13'b110100_0110000);
      run_row("full2", 13'b110100_0110001);
      run_row("full3", 13'b110100_0110001);
      run_row("full4", 13'b110100_0110001);
      run_row("full5", 13'b110100_0000001);
      run_row("fpop6", 13'b110110_0000101);
      run_row("acc7",  13'b110100_0110001);
      for (int i = 0; i < 4; i++) begin
         run_row($sformatf("drn%0d", i), 13'b100010_0000101);
      end
      run_row("idle3", 13'b100000_0000000);

      // Reset mid-transaction drops outstanding entries
      run_row("rpush1", 13'b110100_0110000);
      run_row("rpush2", 13'b110100_0110001);
      run_row("rmid",   13'b010110_0000000);
      run_row("rdok",   13'b100010_0000000);
      run_row("idle4",  13'b100000_0000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
